// File: rtl/safe_pkg.sv
// Shared types and constants for the safe design's serial link blocks.
package safe_pkg;

  localparam int SAFE_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial-in / parallel-out handshake bundle for the receive end of the link.
// Both sides are valid/ready: a transfer happens on a posedge where valid && ready.
interface serial_to_parallel_if #(
  parameter int N = 4
) ();
  logic         sdata;
  logic         svalid;
  logic         sready;
  logic [N-1:0] pdata;
  logic         pvalid;
  logic         pready;

  modport master (
    output sdata, svalid, pready,
    input  sready, pdata, pvalid
  );

  modport slave (
    input  sdata, svalid, pready,
    output sready, pdata, pvalid
  );
endinterface

// File: rtl/serial_to_parallel.sv
// Assembles N serially received bits into a word and holds it until consumed.
// sready depends only on registered state, so there is no pready->sready path.
module serial_to_parallel
  import safe_pkg::*;
#(
  parameter int N         = SAFE_CODE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  serial_to_parallel_if.slave bus,
  output s2p_state_t          state_o
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  s2p_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [N-1:0]     pdata_q, pdata_d;
  logic [N-1:0]     shift_nxt;
  logic             sready;
  logic             accept;
  logic             last_bit;

  assign sready     = (state_q != FULL);
  assign accept     = bus.svalid && sready;
  assign last_bit   = (cnt_q == CNT_W'(N - 1));
  assign bus.sready = sready;
  assign bus.pvalid = (state_q == FULL);
  assign bus.pdata  = pdata_q;
  assign state_o    = state_q;

  // Incoming bit enters at the end opposite to where the first bit must finish.
  always_comb begin
    shift_nxt = shift_q;
    if (MSB_FIRST) begin
      shift_nxt    = shift_q << 1;
      shift_nxt[0] = bus.sdata;
    end else begin
      shift_nxt      = shift_q >> 1;
      shift_nxt[N-1] = bus.sdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pdata_d = pdata_q;
    case (state_q)
      IDLE, SHIFT: begin
        if (accept) begin
          shift_d = shift_nxt;
          if (last_bit) begin
            state_d = FULL;
            cnt_d   = '0;
            pdata_d = shift_nxt;
          end else begin
            state_d = SHIFT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (bus.pready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pdata_q <= pdata_d;
    end
  end

  a_pvalid_full: assert property (@(posedge clk) bus.pvalid == (state_q == FULL));
  a_sready_inv:  assert property (@(posedge clk) bus.sready == !bus.pvalid);
  a_pdata_hold:  assert property (@(posedge clk) disable iff (rst)
                                  (bus.pvalid && !bus.pready) |=> $stable(bus.pdata));

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: N=4 MSB-first, N=4 LSB-first and N=1.
module tb_serial_to_parallel;
  import safe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  serial_to_parallel_if #(.N(4)) if_m ();
  serial_to_parallel_if #(.N(4)) if_l ();
  serial_to_parallel_if #(.N(1)) if_1 ();

  s2p_state_t st_m, st_l, st_1;

  serial_to_parallel #(.N(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(if_m), .state_o(st_m));
  serial_to_parallel #(.N(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l), .state_o(st_l));
  serial_to_parallel #(.N(1), .MSB_FIRST(1'b1)) dut_1 (
    .clk(clk), .rst(rst), .bus(if_1), .state_o(st_1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit to the selected DUT for one edge, then idle its serial side.
  task automatic send(input int sel, input logic b);
    case (sel)
      0:       begin if_m.sdata = b; if_m.svalid = 1'b1; end
      1:       begin if_l.sdata = b; if_l.svalid = 1'b1; end
      default: begin if_1.sdata = b; if_1.svalid = 1'b1; end
    endcase
    tick();
    if_m.svalid = 1'b0; if_m.sdata = 1'bx;
    if_l.svalid = 1'b0; if_l.sdata = 1'bx;
    if_1.svalid = 1'b0; if_1.sdata = 1'bx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (if_m.pvalid !== 1'b0) $display("FAIL rst_pvalid_m: got %b expected 0", if_m.pvalid); else passed++;
    total++; if (if_m.sready !== 1'b1) $display("FAIL rst_sready_m: got %b expected 1", if_m.sready); else passed++;
    total++; if (if_m.pdata !== 4'd0) $display("FAIL rst_pdata_m: got %0d expected 0", if_m.pdata); else passed++;
    total++; if (st_m !== IDLE) $display("FAIL rst_state_m: got %0d expected %0d", st_m, IDLE); else passed++;
    total++; if (if_l.pvalid !== 1'b0 || if_l.pdata !== 4'd0) $display("FAIL rst_l: got pvalid=%b pdata=%0d expected 0/0", if_l.pvalid, if_l.pdata); else passed++;
    total++; if (if_1.pvalid !== 1'b0 || if_1.pdata !== 1'b0) $display("FAIL rst_1: got pvalid=%b pdata=%0d expected 0/0", if_1.pvalid, if_1.pdata); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    if_m.pready = 1'b1;
    send(0, 1'b1);
    send(0, 1'b0);
    send(0, 1'b1);
    total++; if (if_m.pvalid !== 1'b0) $display("FAIL basic_early: got pvalid=%b expected 0", if_m.pvalid); else passed++;
    send(0, 1'b1);
    total++; if (if_m.pvalid !== 1'b1) $display("FAIL basic_pvalid: got %b expected 1", if_m.pvalid); else passed++;
    total++; if (if_m.pdata !== 4'd11) $display("FAIL basic_pdata: got %0d expected 11", if_m.pdata); else passed++;
    total++; if (if_m.sready !== 1'b0) $display("FAIL basic_sready: got %b expected 0", if_m.sready); else passed++;
    tick();
    total++; if (if_m.pvalid !== 1'b0 || if_m.sready !== 1'b1) $display("FAIL basic_after: got pvalid=%b sready=%b expected 0/1", if_m.pvalid, if_m.sready); else passed++;
    if_m.pready = 1'b0;
  endtask

  task automatic test_stall();
    if_m.pready = 1'b0;
    send(0, 1'b1);
    send(0, 1'b1);
    send(0, 1'b0);
    send(0, 1'b0);
    total++; if (if_m.pvalid !== 1'b1 || if_m.pdata !== 4'd12) $display("FAIL stall_word: got pvalid=%b pdata=%0d expected 1/12", if_m.pvalid, if_m.pdata); else passed++;
    // Offered bits during the stall must be refused.
    for (int i = 0; i < 5; i++) begin
      if_m.svalid = 1'b1;
      if_m.sdata  = i[0];
      tick();
      total++;
      if (if_m.pvalid !== 1'b1 || if_m.sready !== 1'b0 || if_m.pdata !== 4'd12)
        $display("FAIL stall_hold%0d: got pvalid=%b sready=%b pdata=%0d expected 1/0/12", i, if_m.pvalid, if_m.sready, if_m.pdata);
      else passed++;
    end
    if_m.svalid = 1'b0;
    if_m.pready = 1'b1;
    tick();
    if_m.pready = 1'b0;
    total++; if (if_m.pvalid !== 1'b0 || if_m.sready !== 1'b1) $display("FAIL stall_release: got pvalid=%b sready=%b expected 0/1", if_m.pvalid, if_m.sready); else passed++;
    total++; if (if_m.pdata !== 4'd12) $display("FAIL stall_keep: got %0d expected 12", if_m.pdata); else passed++;
    total++; if (st_m !== IDLE) $display("FAIL stall_state: got %0d expected %0d", st_m, IDLE); else passed++;
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      send(0, bits[i]);
      if (i < 3) begin
        repeat (3) tick();
        total++; if (if_m.pvalid !== 1'b0) $display("FAIL gaps_early%0d: got pvalid=%b expected 0", i, if_m.pvalid); else passed++;
      end
    end
    total++; if (if_m.pvalid !== 1'b1 || if_m.pdata !== 4'd3) $display("FAIL gaps_word: got pvalid=%b pdata=%0d expected 1/3", if_m.pvalid, if_m.pdata); else passed++;
    if_m.pready = 1'b1;
    tick();
    if_m.pready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(0, 1'b1);
    send(0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (if_m.pvalid !== 1'b0 || if_m.pdata !== 4'd0) $display("FAIL rmid_clear: got pvalid=%b pdata=%0d expected 0/0", if_m.pvalid, if_m.pdata); else passed++;
    send(0, 1'b1);
    send(0, 1'b0);
    send(0, 1'b0);
    total++; if (if_m.pvalid !== 1'b0) $display("FAIL rmid_partial: got pvalid=%b expected 0", if_m.pvalid); else passed++;
    send(0, 1'b0);
    total++; if (if_m.pvalid !== 1'b1 || if_m.pdata !== 4'd8) $display("FAIL rmid_word: got pvalid=%b pdata=%0d expected 1/8", if_m.pvalid, if_m.pdata); else passed++;
    if_m.pready = 1'b1;
    tick();
    if_m.pready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    logic [3:0] words[$];
    int         cycs[$];
    int         idx;
    logic       acc;
    bits = 8'b0001_1100;
    idx  = 0;
    if_m.pready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 8) begin
        if_m.svalid = 1'b1;
        if_m.sdata  = bits[idx];
      end else begin
        if_m.svalid = 1'b0;
      end
      acc = (idx < 8) && if_m.sready;
      tick();
      if (acc) idx++;
      if (if_m.pvalid) begin
        words.push_back(if_m.pdata);
        cycs.push_back(cyc);
      end
    end
    if_m.svalid = 1'b0;
    if_m.pready = 1'b0;
    total++; if (idx !== 8) $display("FAIL b2b_bits: got %0d accepted expected 8", idx); else passed++;
    total++;
    if (words.size() != 2) $display("FAIL b2b_count: got %0d words expected 2", words.size());
    else passed++;
    if (words.size() == 2) begin
      total++; if (words[0] !== 4'd3) $display("FAIL b2b_word0: got %0d expected 3", words[0]); else passed++;
      total++; if (words[1] !== 4'd8) $display("FAIL b2b_word1: got %0d expected 8", words[1]); else passed++;
      total++; if (cycs[1] - cycs[0] != 5) $display("FAIL b2b_spacing: got %0d cycles expected 5", cycs[1] - cycs[0]); else passed++;
      total++; if (cycs[0] != 3) $display("FAIL b2b_latency: got cycle %0d expected 3", cycs[0]); else passed++;
    end
  endtask

  task automatic test_lsb_first();
    if_l.pready = 1'b0;
    send(1, 1'b1);
    send(1, 1'b1);
    send(1, 1'b0);
    send(1, 1'b1);
    total++; if (if_l.pvalid !== 1'b1 || if_l.pdata !== 4'b1011) $display("FAIL lsb_word: got pvalid=%b pdata=%b expected 1/1011", if_l.pvalid, if_l.pdata); else passed++;
    if_l.pready = 1'b1;
    tick();
    if_l.pready = 1'b0;
    total++; if (if_l.pvalid !== 1'b0) $display("FAIL lsb_consume: got pvalid=%b expected 0", if_l.pvalid); else passed++;
  endtask

  task automatic test_n1();
    logic [2:0] bits;
    bits = 3'b101;
    if_1.pready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(2, bits[i]);
      total++;
      if (if_1.pvalid !== 1'b1 || if_1.pdata !== bits[i] || if_1.sready !== 1'b0)
        $display("FAIL n1_word%0d: got pvalid=%b pdata=%b sready=%b expected 1/%b/0", i, if_1.pvalid, if_1.pdata, if_1.sready, bits[i]);
      else passed++;
      if_1.pready = 1'b1;
      tick();
      if_1.pready = 1'b0;
      total++; if (if_1.pvalid !== 1'b0) $display("FAIL n1_consume%0d: got pvalid=%b expected 0", i, if_1.pvalid); else passed++;
    end
  endtask

  initial begin
    if_m.sdata = 1'b0; if_m.svalid = 1'b0; if_m.pready = 1'b0;
    if_l.sdata = 1'b0; if_l.svalid = 1'b0; if_l.pready = 1'b0;
    if_1.sdata = 1'b0; if_1.svalid = 1'b0; if_1.pready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_lsb_first();
    test_n1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
